// File: rtl/i2c_register_block.sv
// -----------------------------------------------------------------------------
// i2c_register_block
//
// APB-slave register file placed between the APB bus and the I2C master core.
// It holds the core's configuration registers (prescaler, command, slave
// address + R/W bit, transmit data) and exposes the core's receive byte and
// status word as read-only registers. Every access completes with zero wait
// states.
//
// Register map (full address decode):
//   0x00 PRESCALER   RW
//   0x01 CMD         RW
//   0x02 ADDRESS_RW  RW
//   0x03 TRANSMIT    RW
//   0x04 RECEIVE     RO  (live RECEIVE_i)
//   0x05 STATUS      RO  (live STATUS_i)
//   others           reserved: read 0x00, writes ignored
//
// Ports:
//   PCLK_i        clock, all state changes on the rising edge
//   PRESET_N_i    synchronous reset, ACTIVE-HIGH despite the legacy name
//   PSEL_i        APB select
//   PENABLE_i     APB enable (access phase)
//   PWRITE_i      1 = write, 0 = read
//   PADDR_i       register address
//   PWDATA_i      write data
//   PRDATA_o      read data (combinational)
//   PREADY_o      transfer complete (combinational, always in access phase)
//   RECEIVE_i     byte from the receive FIFO
//   STATUS_i      status word from the I2C core
//   PRESCALER_o   PRESCALER register contents
//   CMD_o         CMD register contents
//   ADDRESS_RW_o  ADDRESS_RW register contents
//   TRANSMIT_o    TRANSMIT register contents (feeds the transmit FIFO)
//   PSLVERR_o     slave error, only present when I2C_REGBLK_PSLVERR_EN is
//                 defined
//
// Optional feature macro: I2C_REGBLK_PSLVERR_EN
//   When defined, PSLVERR_o flags access phases that target a reserved
//   address or write to a read-only register. The access is otherwise
//   handled exactly as without the macro (write ignored, reserved reads 0).
//
// Handshake: a transfer is a setup cycle (PSEL_i=1, PENABLE_i=0) followed by
// an access cycle (PSEL_i=1, PENABLE_i=1). PREADY_o is asserted for the whole
// access cycle, so the transfer ends on the rising edge that closes it; a
// write commits on exactly that edge. PENABLE_i without PSEL_i is ignored.
// -----------------------------------------------------------------------------
module i2c_register_block #(
  parameter int                    ADDR_WIDTH    = 8,
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] PRESCALER_RST = '0
) (
  input  logic                  PCLK_i,
  input  logic                  PRESET_N_i,
  input  logic                  PSEL_i,
  input  logic                  PENABLE_i,
  input  logic                  PWRITE_i,
  input  logic [ADDR_WIDTH-1:0] PADDR_i,
  input  logic [DATA_WIDTH-1:0] PWDATA_i,
  output logic [DATA_WIDTH-1:0] PRDATA_o,
  output logic                  PREADY_o,
`ifdef I2C_REGBLK_PSLVERR_EN
  output logic                  PSLVERR_o,
`endif
  input  logic [DATA_WIDTH-1:0] RECEIVE_i,
  input  logic [DATA_WIDTH-1:0] STATUS_i,
  output logic [DATA_WIDTH-1:0] PRESCALER_o,
  output logic [DATA_WIDTH-1:0] CMD_o,
  output logic [DATA_WIDTH-1:0] ADDRESS_RW_o,
  output logic [DATA_WIDTH-1:0] TRANSMIT_o
);

  localparam logic [ADDR_WIDTH-1:0] A_PRESCALER  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_CMD        = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_ADDRESS_RW = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_TRANSMIT   = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_RECEIVE    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS     = ADDR_WIDTH'(5);

  logic [DATA_WIDTH-1:0] r_prescaler;
  logic [DATA_WIDTH-1:0] r_cmd;
  logic [DATA_WIDTH-1:0] r_address_rw;
  logic [DATA_WIDTH-1:0] r_transmit;

  logic                  w_access;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_access = PSEL_i & PENABLE_i;
  assign w_wr_en  = w_access & PWRITE_i;
  assign PREADY_o = w_access;

  // Reset is checked first so it wins over a write landing on the same edge,
  // including one in the middle of a transfer.
  always_ff @(posedge PCLK_i) begin
    if (PRESET_N_i) begin
      r_prescaler  <= PRESCALER_RST;
      r_cmd        <= '0;
      r_address_rw <= '0;
      r_transmit   <= '0;
    end else if (w_wr_en) begin
      case (PADDR_i)
        A_PRESCALER:  r_prescaler  <= PWDATA_i;
        A_CMD:        r_cmd        <= PWDATA_i;
        A_ADDRESS_RW: r_address_rw <= PWDATA_i;
        A_TRANSMIT:   r_transmit   <= PWDATA_i;
        default:      ; // RO and reserved: no side effects
      endcase
    end
  end

  // Read data is valid during both setup and access phase of a read; it is
  // forced to zero otherwise so the shared bus sees a quiet slave.
  always_comb begin
    w_rdata = '0;
    if (PSEL_i && !PWRITE_i) begin
      case (PADDR_i)
        A_PRESCALER:  w_rdata = r_prescaler;
        A_CMD:        w_rdata = r_cmd;
        A_ADDRESS_RW: w_rdata = r_address_rw;
        A_TRANSMIT:   w_rdata = r_transmit;
        A_RECEIVE:    w_rdata = RECEIVE_i;
        A_STATUS:     w_rdata = STATUS_i;
        default:      w_rdata = '0;
      endcase
    end
  end

  assign PRDATA_o     = w_rdata;
  assign PRESCALER_o  = r_prescaler;
  assign CMD_o        = r_cmd;
  assign ADDRESS_RW_o = r_address_rw;
  assign TRANSMIT_o   = r_transmit;

`ifdef I2C_REGBLK_PSLVERR_EN
  logic w_reserved;
  logic w_ro_write;

  assign w_reserved = (PADDR_i > A_STATUS);
  assign w_ro_write = PWRITE_i & ((PADDR_i == A_RECEIVE) | (PADDR_i == A_STATUS));
  assign PSLVERR_o  = w_access & (w_reserved | w_ro_write);
`endif

endmodule

// File: tb/tb_i2c_register_block.sv
// -----------------------------------------------------------------------------
// tb_i2c_register_block
//
// Directed bench for i2c_register_block. A shadow model of the four RW
// registers tracks committed writes; read transfers push their expected data
// into exp_q in the setup phase and pop it when PRDATA_o is sampled in the
// access phase. Inputs change on the falling edge, outputs are sampled either
// just after a falling-edge drive or 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_i2c_register_block;

  localparam int         AW      = 8;
  localparam int         DW      = 8;
  localparam logic [7:0] PRE_RST = 8'h5C;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          psel    = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite  = 1'b0;
  logic [AW-1:0] paddr   = '0;
  logic [DW-1:0] pwdata  = '0;
  logic [DW-1:0] receive = '0;
  logic [DW-1:0] status  = '0;
  logic [DW-1:0] prdata;
  logic          pready;
  logic [DW-1:0] presc_o, cmd_o, addr_rw_o, tx_o;
`ifdef I2C_REGBLK_PSLVERR_EN
  logic          pslverr;
`endif

  i2c_register_block #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .PRESCALER_RST (PRE_RST)
  ) dut (
    .PCLK_i       (clk),
    .PRESET_N_i   (rst),
    .PSEL_i       (psel),
    .PENABLE_i    (penable),
    .PWRITE_i     (pwrite),
    .PADDR_i      (paddr),
    .PWDATA_i     (pwdata),
    .PRDATA_o     (prdata),
    .PREADY_o     (pready),
`ifdef I2C_REGBLK_PSLVERR_EN
    .PSLVERR_o    (pslverr),
`endif
    .RECEIVE_i    (receive),
    .STATUS_i     (status),
    .PRESCALER_o  (presc_o),
    .CMD_o        (cmd_o),
    .ADDRESS_RW_o (addr_rw_o),
    .TRANSMIT_o   (tx_o)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_regs [4];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    if (a < 8'd4)       return m_regs[a[1:0]];
    else if (a == 8'd4) return receive;
    else if (a == 8'd5) return status;
    else                return 8'h00;
  endfunction

  function automatic logic model_err(input logic [7:0] a, input logic wr);
    return (a > 8'd5) || (wr && (a == 8'd4 || a == 8'd5));
  endfunction

  task automatic model_reset();
    m_regs[0] = PRE_RST;
    m_regs[1] = 8'h00;
    m_regs[2] = 8'h00;
    m_regs[3] = 8'h00;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".prescaler"},  presc_o,   m_regs[0]);
    check({tag, ".cmd"},        cmd_o,     m_regs[1]);
    check({tag, ".address_rw"}, addr_rw_o, m_regs[2]);
    check({tag, ".transmit"},   tx_o,      m_regs[3]);
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic idle();
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_write(input string tag, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    #1;
    check({tag, ".setup_pready"}, {7'b0, pready}, 8'h00);
    check({tag, ".setup_prdata"}, prdata, 8'h00);
    @(negedge clk);
    penable = 1'b1;
    #1;
    check({tag, ".access_pready"}, {7'b0, pready}, 8'h01);
`ifdef I2C_REGBLK_PSLVERR_EN
    check({tag, ".pslverr"}, {7'b0, pslverr}, {7'b0, model_err(a, 1'b1)});
`endif
    @(posedge clk);
    #1;
    if (a < 8'd4) m_regs[a[1:0]] = d;
    check_outputs(tag);
  endtask

  task automatic apb_read(input string tag, input logic [7:0] a);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    exp_q.push_back(model_read(a));
    #1;
    check({tag, ".setup_pready"}, {7'b0, pready}, 8'h00);
    check({tag, ".setup_prdata"}, prdata, model_read(a));
    @(negedge clk);
    penable = 1'b1;
    #1;
    check({tag, ".access_pready"}, {7'b0, pready}, 8'h01);
`ifdef I2C_REGBLK_PSLVERR_EN
    check({tag, ".pslverr"}, {7'b0, pslverr}, {7'b0, model_err(a, 1'b0)});
`endif
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end else begin
      check({tag, ".prdata"}, prdata, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [7:0] ra, rd;
    model_reset();

    // Reset: held for two edges, then released.
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset.prdata_idle", prdata, 8'h00);
    check("reset.pready_idle", {7'b0, pready}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Write then read ADDRESS_RW.
    apb_write("wr02", 8'h02, 8'hAB);
    apb_read("rd02", 8'h02);
    idle();
    #1;
    check("idle.pready", {7'b0, pready}, 8'h00);
    check("idle.prdata", prdata, 8'h00);

    // All RW registers, back-to-back transfers.
    apb_write("wr00", 8'h00, 8'h11);
    apb_write("wr01", 8'h01, 8'h22);
    apb_write("wr02b", 8'h02, 8'h33);
    apb_write("wr03", 8'h03, 8'h44);
    apb_read("rd00", 8'h00);
    apb_read("rd01", 8'h01);
    apb_read("rd02b", 8'h02);
    apb_read("rd03", 8'h03);

    // Read-only registers are live inputs.
    receive = 8'h5A;
    status  = 8'hC3;
    apb_read("rd04", 8'h04);
    apb_read("rd05", 8'h05);
    receive = 8'hA7;
    apb_read("rd04_live", 8'h04);

    // Writes to RO and reserved addresses change nothing.
    apb_write("wr04", 8'h04, 8'hFF);
    apb_write("wr05", 8'h05, 8'hFF);
    apb_write("wr10", 8'h10, 8'hFF);
    apb_read("rd10", 8'h10);
    apb_read("rdFF", 8'hFF);
    apb_read("rd04_after", 8'h04);

    // Setup phase without an access phase never writes.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h01; pwdata = 8'h77;
    @(posedge clk);
    #1;
    check("abort_setup.cmd", cmd_o, m_regs[1]);
    idle();
    @(posedge clk);
    #1;
    check_outputs("abort");

    // PENABLE without PSEL is ignored.
    @(negedge clk);
    psel = 1'b0; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hEE;
    #1;
    check("nosel.pready", {7'b0, pready}, 8'h00);
    @(posedge clk);
    #1;
    check_outputs("nosel");
    @(negedge clk);
    pwrite = 1'b0;
    #1;
    check("nosel.prdata", prdata, 8'h00);

    // Read immediately after write of the same register.
    apb_write("raw_wr", 8'h01, 8'h5E);
    apb_read("raw_rd", 8'h01);

    // Random back-to-back write/read pairs over valid and reserved addresses.
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 7));
      rd = 8'($urandom_range(0, 255));
      apb_write("rnd_wr", ra, rd);
      apb_read("rnd_rd", ra);
    end

    // Reset arriving on the access edge of a write wins.
    apb_write("pre_rst", 8'h00, 8'h3C);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h03; pwdata = 8'h99;
    @(negedge clk);
    penable = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check_outputs("mid_rst");
    check("mid_rst.transmit", tx_o, 8'h00);
    @(negedge clk);
    rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    apb_read("post_rst", 8'h03);

    check("queue_drained", 8'(exp_q.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
